// File: rtl/clock_set_controller.sv
// clock_set_controller
// Time-set controller for the digital clock. In RUN the counter chain is free
// to advance. A mode press freezes the counters and enters an edit sequence
// (hours, then minutes) driven by inc/dec presses. A final mode press commits
// the edited time with a one-cycle parallel load. If no button activity is
// seen for TIMEOUT_S seconds while editing, the edit is abandoned without a load.
//
// Parameters:
//   TIMEOUT_S      - idle seconds before set mode is abandoned (1..255)
// Optional feature macro:
//   AUTO_REPEAT_EN - a held inc/dec button keeps stepping once per second,
//                    starting from the third tick after the press
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   tick_1s        - one-cycle pulse per second from the clock divider
//   btn_mode/inc/dec - debounced, clk-synchronous button levels
//   cur_minutes/hours - live counter values, captured when editing starts
//   run_en         - counters may advance
//   load           - one-cycle load strobe; load_seconds/minutes/hours are
//                    the load values
//   set_mode       - 0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT
//   blink          - blink enable for the field being edited
module clock_set_controller #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_minutes,
  input  logic [4:0] cur_hours,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_seconds,
  output logic [5:0] load_minutes,
  output logic [4:0] load_hours,
  output logic [1:0] set_mode,
  output logic       blink
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HR  = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;
  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_S);

  logic [1:0] state_q, state_d;
  logic [4:0] edit_hr_q, edit_hr_d;
  logic [5:0] edit_min_q, edit_min_d;
  logic [7:0] tmo_q, tmo_d;
  logic       blink_q, blink_d;
  logic       run_en_q, run_en_d;
  logic       load_q, load_d;
  logic [5:0] load_min_q, load_min_d;
  logic [4:0] load_hr_q, load_hr_d;
  logic       mode_prev_q, inc_prev_q, dec_prev_q;

  logic ev_mode, ev_inc, ev_dec;
  logic in_set, next_in_set;
  logic step_up, step_dn;
  logic rep_step_up, rep_step_dn;

  // Wrapping +/-1 on the hours field (0..23).
  function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Wrapping +/-1 on the minutes field (0..59).
  function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  assign ev_mode = btn_mode & ~mode_prev_q;
  assign ev_inc  = btn_inc & ~inc_prev_q;
  assign ev_dec  = btn_dec & ~dec_prev_q;
  assign in_set  = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);

`ifdef AUTO_REPEAT_EN
  logic       rep_armed_q, rep_armed_d;
  logic       rep_up_q, rep_up_d;
  logic [1:0] rep_cnt_q, rep_cnt_d;
  logic       rep_held;
  logic       rep_fire;

  // Repeat is only live while the armed button alone stays held.
  assign rep_held    = rep_up_q ? (btn_inc & ~btn_dec) : (btn_dec & ~btn_inc);
  assign rep_fire    = in_set & ~ev_mode & ~ev_inc & ~ev_dec & rep_armed_q &
                       rep_held & tick_1s & (rep_cnt_q == 2'd2);
  assign rep_step_up = rep_fire & rep_up_q;
  assign rep_step_dn = rep_fire & ~rep_up_q;

  // Auto-repeat arming and tick holdoff (two silent ticks, then steps).
  always_comb begin
    rep_armed_d = rep_armed_q;
    rep_up_d    = rep_up_q;
    rep_cnt_d   = rep_cnt_q;
    if (!in_set || ev_mode || (ev_inc && ev_dec)) begin
      rep_armed_d = 1'b0;
    end else if (ev_inc || ev_dec) begin
      rep_armed_d = 1'b1;
      rep_up_d    = ev_inc;
      rep_cnt_d   = 2'd0;
    end else if (rep_armed_q && !rep_held) begin
      rep_armed_d = 1'b0;
    end else if (rep_armed_q && tick_1s && (rep_cnt_q != 2'd2)) begin
      rep_cnt_d = rep_cnt_q + 2'd1;
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_armed_q <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_cnt_q   <= 2'd0;
    end else begin
      rep_armed_q <= rep_armed_d;
      rep_up_q    <= rep_up_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  assign rep_step_up = 1'b0;
  assign rep_step_dn = 1'b0;
`endif

  // A mode event suppresses any edit; inc and dec together cancel out.
  assign step_up = (ev_inc & ~ev_dec & ~ev_mode) | rep_step_up;
  assign step_dn = (ev_dec & ~ev_inc & ~ev_mode) | rep_step_dn;

  // Next state, edit fields and idle timeout.
  always_comb begin
    state_d    = state_q;
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_RUN: begin
        tmo_d = 8'd0;
        if (ev_mode) begin
          state_d    = ST_SET_HR;
          edit_hr_d  = cur_hours;
          edit_min_d = cur_minutes;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_HR, ST_SET_MIN: begin
        // Activity in the timeout cycle wins over the timeout.
        if (ev_mode || ev_inc || ev_dec || step_up || step_dn) begin
          tmo_d = 8'd0;
        end else if (tick_1s) begin
          if (tmo_q + 8'd1 == TMO_LIMIT) begin
            tmo_d   = 8'd0;
            state_d = ST_RUN;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end else begin
          tmo_d = tmo_q;
        end
        if (ev_mode) begin
          state_d = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_COMMIT;
        end else begin
          state_d = state_d;
        end
        if (state_q == ST_SET_HR) begin
          if (step_up || step_dn) edit_hr_d = hr_step(edit_hr_q, step_up);
          else                    edit_hr_d = edit_hr_q;
        end else begin
          if (step_up || step_dn) edit_min_d = min_step(edit_min_q, step_up);
          else                    edit_min_d = edit_min_q;
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
        tmo_d   = 8'd0;
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = 8'd0;
      end
    endcase
  end

  assign next_in_set = (state_d == ST_SET_HR) || (state_d == ST_SET_MIN);

  // Output next-values, derived from the next state so outputs stay registered.
  always_comb begin
    run_en_d   = (state_d == ST_RUN);
    load_d     = (state_d == ST_COMMIT);
    load_min_d = load_min_q;
    load_hr_d  = load_hr_q;
    if (load_d) begin
      load_min_d = edit_min_d;
      load_hr_d  = edit_hr_d;
    end else begin
      load_min_d = load_min_q;
      load_hr_d  = load_hr_q;
    end
    if (!next_in_set)              blink_d = 1'b0;
    else if (in_set && tick_1s)    blink_d = ~blink_q;
    else                           blink_d = blink_q;
  end

  // State, edit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      edit_hr_q   <= 5'd0;
      edit_min_q  <= 6'd0;
      tmo_q       <= 8'd0;
      blink_q     <= 1'b0;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      load_min_q  <= 6'd0;
      load_hr_q   <= 5'd0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      tmo_q       <= tmo_d;
      blink_q     <= blink_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      load_min_q  <= load_min_d;
      load_hr_q   <= load_hr_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      dec_prev_q  <= btn_dec;
    end
  end

  assign run_en       = run_en_q;
  assign load         = load_q;
  assign load_seconds = 6'd0;
  assign load_minutes = load_min_q;
  assign load_hours   = load_hr_q;
  assign set_mode     = state_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Testbench for clock_set_controller: directed scenarios plus randomized
// button/tick traffic, checked every cycle against a behavioural model.
module tb_clock_set_controller;

  localparam int TMO = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1s, btn_mode, btn_inc, btn_dec;
  logic [5:0] cur_minutes;
  logic [4:0] cur_hours;
  logic       run_en, load, blink;
  logic [5:0] load_seconds, load_minutes;
  logic [4:0] load_hours;
  logic [1:0] set_mode;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_mode, m_hr, m_min, m_idle, m_lh, m_lm, m_rdir, m_rticks;
  bit m_blink, m_load, m_pm, m_pi, m_pd;

  bit rand_cur;
  int fix_h, fix_m;

  clock_set_controller #(.TIMEOUT_S(TMO)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_minutes(cur_minutes), .cur_hours(cur_hours),
    .run_en(run_en), .load(load), .load_seconds(load_seconds),
    .load_minutes(load_minutes), .load_hours(load_hours),
    .set_mode(set_mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hr = 0; m_min = 0; m_idle = 0; m_lh = 0; m_lm = 0;
    m_rdir = 0; m_rticks = 0; m_blink = 0; m_load = 0;
    m_pm = 0; m_pi = 0; m_pd = 0;
  endtask

  // One clock edge of the clock-setting rules.
  task automatic model_step(input bit t, input bit bm, input bit bi, input bit bd,
                            input int ch, input int cm);
    bit ev_m, ev_i, ev_d, rep, held;
    int nxt, step;
    ev_m = bm && !m_pm; ev_i = bi && !m_pi; ev_d = bd && !m_pd;
    nxt = m_mode; step = 0; rep = 0; held = 0;
    if (m_mode == 0) begin
      m_idle = 0; m_rdir = 0;
      if (ev_m) begin nxt = 1; m_hr = ch; m_min = cm; end
    end else if (m_mode == 3) begin
      nxt = 0;
    end else begin
`ifdef AUTO_REPEAT_EN
      if (ev_m) m_rdir = 0;
      else if (ev_i && !ev_d) begin m_rdir = 1; m_rticks = 0; end
      else if (ev_d && !ev_i) begin m_rdir = -1; m_rticks = 0; end
      else if (ev_i && ev_d) m_rdir = 0;
      else if (m_rdir != 0) begin
        held = (m_rdir > 0) ? (bi && !bd) : (bd && !bi);
        if (!held) m_rdir = 0;
        else if (t) begin m_rticks++; if (m_rticks > 2) rep = 1; end
      end
`endif
      if (!ev_m) begin
        if (ev_i && !ev_d) step = 1;
        else if (ev_d && !ev_i) step = -1;
        else if (rep) step = m_rdir;
      end
      if (ev_m || ev_i || ev_d || rep) m_idle = 0;
      else if (t) begin
        m_idle++;
        if (m_idle == TMO) begin nxt = 0; m_idle = 0; end
      end
      if (ev_m) nxt = (m_mode == 1) ? 2 : 3;
      if (m_mode == 1) m_hr = (m_hr + step + 24) % 24;
      else             m_min = (m_min + step + 60) % 60;
    end
    if (nxt == 1 || nxt == 2) begin
      if (t && (m_mode == 1 || m_mode == 2)) m_blink = !m_blink;
    end else begin
      m_blink = 0;
    end
    m_load = (nxt == 3);
    if (m_load) begin m_lh = m_hr; m_lm = m_min; end
    m_mode = nxt;
    m_pm = bm; m_pi = bi; m_pd = bd;
  endtask

  task automatic compare_all();
    check_val("run_en", run_en, (m_mode == 0) ? 1 : 0);
    check_val("load", load, m_load);
    check_val("set_mode", set_mode, m_mode);
    check_val("blink", blink, m_blink);
    check_val("load_minutes", load_minutes, m_lm);
    check_val("load_hours", load_hours, m_lh);
    check_val("load_seconds", load_seconds, 0);
  endtask

  // Drive one cycle of inputs (called at negedge), step model, compare.
  task automatic cycle(input bit t, input bit bm, input bit bi, input bit bd);
    int ch, cm;
    if (rand_cur) begin ch = $urandom_range(23); cm = $urandom_range(59); end
    else begin ch = fix_h; cm = fix_m; end
    tick_1s = t; btn_mode = bm; btn_inc = bi; btn_dec = bd;
    cur_hours = 5'(ch); cur_minutes = 6'(cm);
    @(posedge clk);
    model_step(t, bm, bi, bd, ch, cm);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input bit bm, input bit bi, input bit bd);
    cycle(1'b0, bm, bi, bd);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_gap();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit bm, bi, bd, quiet;
    rst = 1'b1; tick_1s = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hours = 5'd0; cur_minutes = 6'd0; rand_cur = 1'b0; fix_h = 0; fix_m = 0;
    model_reset();
    #12;
    check_val("rst_run_en", run_en, 1);
    check_val("rst_load", load, 0);
    check_val("rst_set_mode", set_mode, 0);
    check_val("rst_blink", blink, 0);
    @(negedge clk); rst = 1'b0;

    // Idle ticks in RUN
    for (int i = 0; i < 5; i++) begin tick_gap(); cycle(1'b0, 1'b0, 1'b0, 1'b0); end
    check_val("idle_run_en", run_en, 1);

    // 23:59 -> inc both -> 00:00
    fix_h = 23; fix_m = 59;
    press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(0, 1, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("wrap_load", load, 1);
    check_val("wrap_run_en_low", run_en, 0);
    check_val("wrap_hr", load_hours, 0);
    check_val("wrap_min", load_minutes, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("wrap_load_off", load, 0);
    check_val("wrap_run_en_back", run_en, 1);

    // 00:00 -> dec hour, dec minute twice -> 23:58
    fix_h = 0; fix_m = 0;
    press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("dec_hr", load_hours, 23);
    check_val("dec_min", load_minutes, 58);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout abandons SET_HR after TMO idle ticks
    fix_h = 7; fix_m = 7;
    press(1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick_gap();
    check_val("tmo_before", set_mode, 1);
    tick_gap();
    check_val("tmo_after", set_mode, 0);
    check_val("tmo_no_load", load, 0);
    // Press in the timeout cycle keeps SET_HR
    press(1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick_gap();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("tmo_press_wins", set_mode, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    press(1, 0, 0); press(1, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Mode+inc together, then inc+dec together
    fix_h = 10; fix_m = 20;
    press(1, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("mode_over_inc", set_mode, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    press(0, 1, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("prio_hr", load_hours, 10);
    check_val("prio_min", load_minutes, 20);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-edit
    fix_h = 5; fix_m = 5;
    press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
    rst = 1'b1; #1;
    model_reset();
    check_val("midrst_run_en", run_en, 1);
    check_val("midrst_mode", set_mode, 0);
    check_val("midrst_load", load, 0);
    @(negedge clk); rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AUTO_REPEAT_EN
    // Held inc from minute 58: step on press, then ticks 3, 4, 5
    fix_h = 12; fix_m = 58;
    press(1, 0, 0); press(1, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0); cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("repeat_min", load_minutes, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic: busy phases and quiet phases (to reach timeouts)
    rand_cur = 1'b1;
    bm = 0; bi = 0; bd = 0;
    for (int blk = 0; blk < 24; blk++) begin
      quiet = ($urandom_range(2) == 0);
      for (int c = 0; c < 150; c++) begin
        if (quiet) begin
          bm = 0; bi = 0; bd = 0;
        end else begin
          if ($urandom_range(9) == 0) bm = !bm;
          if ($urandom_range(5) == 0) bi = !bi;
          if ($urandom_range(5) == 0) bd = !bd;
        end
        cycle(($urandom_range(2) == 0), bm, bi, bd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
